// File: rtl/cla_seq_add_ctrl_pkg.sv
// Shared types and constants for the sequential CLA adder.
// Reduction logic is compiled in only when CLA_SEQ_MOD_REDUCE_EN is defined.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_SLICE_WIDTH = 16;

  // Goldilocks prime 2^64 - 2^32 + 1.
  localparam logic [63:0] GOLDILOCKS_P = 64'hFFFF_FFFF_0000_0001;

  function automatic int num_slices(input int dw, input int sw);
    return dw / sw;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_seq_add_ctrl_slice.sv
// SLICE_WIDTH-bit carry-lookahead adder: 4-bit CLA groups rippled through
// group generate/propagate terms.
module cla_slice
  import cla_seq_pkg::*;
#(
  parameter int SLICE_WIDTH = DEF_SLICE_WIDTH
) (
  input  logic [SLICE_WIDTH-1:0] a,
  input  logic [SLICE_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [SLICE_WIDTH-1:0] s,
  output logic                   cout
);

  localparam int NG = SLICE_WIDTH / 4;

  logic [NG:0] gc;

  assign gc[0] = cin;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    logic [3:0] g, p, c;
    logic       gg, gp;

    assign g    = a[4*j +: 4] & b[4*j +: 4];
    assign p    = a[4*j +: 4] ^ b[4*j +: 4];
    assign c[0] = gc[j];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign gp   = &p;

    assign gc[j+1]     = gg | (gp & gc[j]);
    assign s[4*j +: 4] = p ^ c;
  end

  assign cout = gc[NG];

endmodule

// File: rtl/cla_seq_add_ctrl.sv
// Multi-cycle DATA_WIDTH add time-sharing one CLA slice, LSB slice first.
// Define CLA_SEQ_MOD_REDUCE_EN to add a second pass reducing modulo MODULUS.
module cla_seq_add_ctrl
  import cla_seq_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    SLICE_WIDTH = DEF_SLICE_WIDTH,
  parameter logic [DATA_WIDTH-1:0] MODULUS     = DATA_WIDTH'(GOLDILOCKS_P)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum_out,
  output logic                  carry_out,
  output logic                  busy
);

  localparam int              NS     = num_slices(DATA_WIDTH, SLICE_WIDTH);
  localparam int              IW     = idx_w(NS);
  localparam logic [IW-1:0]   K_LAST = IW'(NS - 1);

  if (DATA_WIDTH % SLICE_WIDTH != 0) begin : g_chk_dw
    $error("DATA_WIDTH must be a multiple of SLICE_WIDTH");
  end
  if (SLICE_WIDTH % 4 != 0) begin : g_chk_sw
    $error("SLICE_WIDTH must be a multiple of 4");
  end
  if (MODULUS == '0) begin : g_chk_mod
    $error("MODULUS must be nonzero");
  end

  state_e                       state, state_nxt;
  logic [NS-1:0][SLICE_WIDTH-1:0] a_q, b_q, s_q, s_nxt;
  logic [IW-1:0]                k;
  logic                         carry;
  logic                         cy_q;
  logic [DATA_WIDTH-1:0]        sum_q;
  logic                         last;

  logic [SLICE_WIDTH-1:0]       op_a, op_b, sl_sum;
  logic                         sl_cout;

`ifdef CLA_SEQ_MOD_REDUCE_EN
  localparam logic [NS-1:0][SLICE_WIDTH-1:0] MOD_SL = MODULUS;
  logic [NS-1:0][SLICE_WIDTH-1:0] t_q, t_nxt;
`endif

  assign last = (k == K_LAST);

  // Single shared slice; SUB pass adds ~MODULUS with carry-in 1 (i.e. s - p).
  always_comb begin
    op_a = a_q[k];
    op_b = b_q[k];
`ifdef CLA_SEQ_MOD_REDUCE_EN
    if (state == SUB) begin
      op_a = s_q[k];
      op_b = ~MOD_SL[k];
    end
`endif
  end

  cla_slice #(.SLICE_WIDTH(SLICE_WIDTH)) u_slice (
    .a    (op_a),
    .b    (op_b),
    .cin  (carry),
    .s    (sl_sum),
    .cout (sl_cout)
  );

  always_comb begin
    s_nxt    = s_q;
    s_nxt[k] = sl_sum;
  end

`ifdef CLA_SEQ_MOD_REDUCE_EN
  always_comb begin
    t_nxt    = t_q;
    t_nxt[k] = sl_sum;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ADD;
      end
      ADD: begin
`ifdef CLA_SEQ_MOD_REDUCE_EN
        if (last) state_nxt = SUB;
`else
        if (last) state_nxt = DONE;
`endif
      end
`ifdef CLA_SEQ_MOD_REDUCE_EN
      SUB: begin
        if (last) state_nxt = DONE;
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      k     <= '0;
      carry <= 1'b0;
      cy_q  <= 1'b0;
      sum_q <= '0;
`ifdef CLA_SEQ_MOD_REDUCE_EN
      t_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a_in;
            b_q   <= b_in;
            k     <= '0;
            carry <= 1'b0;
          end
        end
        ADD: begin
          s_q[k] <= sl_sum;
          carry  <= sl_cout;
          k      <= k + IW'(1);
          if (last) begin
            k    <= '0;
            cy_q <= sl_cout;
`ifdef CLA_SEQ_MOD_REDUCE_EN
            carry <= 1'b1;
`else
            sum_q <= s_nxt;
`endif
          end
        end
`ifdef CLA_SEQ_MOD_REDUCE_EN
        SUB: begin
          t_q[k] <= sl_sum;
          carry  <= sl_cout;
          k      <= k + IW'(1);
          // Final carry is the no-borrow flag: subtract if s >= p or A+B wrapped.
          if (last) begin
            k     <= '0;
            sum_q <= (cy_q | sl_cout) ? t_nxt : s_q;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign sum_out   = sum_q;
  assign carry_out = cy_q;

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Directed bench for cla_seq_add_ctrl; expectations follow CLA_SEQ_MOD_REDUCE_EN.
module tb_cla_seq_add_ctrl;

`ifdef CLA_SEQ_MOD_REDUCE_EN
  localparam int  LAT = 8;
  localparam bit  RED = 1'b1;
`else
  localparam int  LAT = 4;
  localparam bit  RED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, carry_out, busy;
  logic [63:0] a_in, b_in, sum_out;

  int checks = 0;
  int fails  = 0;

  cla_seq_add_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_s, input logic exp_c);
    int n, lat;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, ":ready_wait"}, 64'(n < 50), 64'd1);
    a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check({tag, ":busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
    check({tag, ":latency"}, 64'(lat), 64'(LAT));
    check({tag, ":sum"}, sum_out, exp_s);
    check({tag, ":carry"}, 64'(carry_out), 64'(exp_c));
    check({tag, ":in_ready_done"}, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":out_valid_clr"}, 64'(out_valid), 64'd0);
    check({tag, ":in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] held;
    int          n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("rst:in_ready",  64'(in_ready),  64'd1);
    check("rst:out_valid", 64'(out_valid), 64'd0);
    check("rst:busy",      64'(busy),      64'd0);
    check("rst:sum",       sum_out,        64'd0);
    check("rst:carry",     64'(carry_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("allones_p1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
           RED ? 64'h0000_0000_FFFF_FFFF : 64'd0, 1'b1);
    run_op("pm1_p1", 64'hFFFF_FFFF_0000_0000, 64'd1,
           RED ? 64'd0 : 64'hFFFF_FFFF_0000_0001, 1'b0);
    run_op("pm1_pm1", 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000,
           RED ? 64'hFFFF_FFFE_FFFF_FFFF : 64'hFFFF_FFFE_0000_0000, 1'b1);
    run_op("3_5", 64'd3, 64'd5, 64'd8, 1'b0);
    run_op("mixed", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111,
           64'h1234_5678_9ABC_DF00, 1'b0);
    run_op("slice_cy", 64'h0000_0000_0000_FFFF, 64'd1, 64'h0000_0000_0001_0000, 1'b0);

    // Backpressure: hold result in DONE while in_valid pulses are ignored.
    a_in = 64'h1234; b_in = 64'h1111; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); @(negedge clk); n++; end
    check("bp:latency", 64'(n), 64'(LAT));
    held = sum_out;
    check("bp:sum", held, 64'h2345);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a_in = 64'(i) * 64'h1_0001; b_in = 64'h55;
      @(posedge clk); @(negedge clk);
      check("bp:hold_sum",   sum_out,         held);
      check("bp:hold_valid", 64'(out_valid),  64'd1);
      check("bp:hold_ready", 64'(in_ready),   64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("bp:in_ready_back", 64'(in_ready), 64'd1);
    check("bp:out_valid_clr", 64'(out_valid), 64'd0);

    // Reset asserted so that it is sampled on the second ADD beat.
    a_in = 64'hFFFF_FFFF_FFFF_FFFF; b_in = 64'd1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("midrst:in_ready",  64'(in_ready),  64'd1);
    check("midrst:out_valid", 64'(out_valid), 64'd0);
    check("midrst:sum",       sum_out,        64'd0);
    check("midrst:busy",      64'(busy),      64'd0);
    check("midrst:carry",     64'(carry_out), 64'd0);
    run_op("post_rst_3_5", 64'd3, 64'd5, 64'd8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
